// File: rtl/pipe_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard/sequencing
//               controller: FSM state encoding and forwarding select codes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_pkg;

   // Controller state: normal issue, or one-cycle registered branch redirect
   typedef enum logic {
      RUN      = 1'b0,
      REDIRECT = 1'b1
   } state_e;

   // ALU operand source selects
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/forward_unit.sv
//------------------------------------------------------------------------------
// Module      : forward_unit
// Description : Combinational EX-stage operand forwarding. Chooses, for each of
//               rs and rt, between the register file, the EX/MEM result and
//               the MEM/WB result. The younger (MEM) producer wins; $0 never
//               matches.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module forward_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] ex_rs,
   input  logic [4:0] ex_rt,
   input  logic       mem_reg_write,
   input  logic [4:0] mem_write_reg,
   input  logic       wb_reg_write,
   input  logic [4:0] wb_write_reg,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   logic mem_valid;
   logic wb_valid;

   // A producer only counts if it writes and its destination is not $0
   assign mem_valid = mem_reg_write && (mem_write_reg != 5'd0);
   assign wb_valid  = wb_reg_write  && (wb_write_reg  != 5'd0);

   // Per-operand select, MEM before WB so the most recent value is used
   always_comb begin
      fwd_a = FWD_REG;
      fwd_b = FWD_REG;
      if (mem_valid && (mem_write_reg == ex_rs)) begin
         fwd_a = FWD_MEM;
      end else if (wb_valid && (wb_write_reg == ex_rs)) begin
         fwd_a = FWD_WB;
      end
      if (mem_valid && (mem_write_reg == ex_rt)) begin
         fwd_b = FWD_MEM;
      end else if (wb_valid && (wb_write_reg == ex_rt)) begin
         fwd_b = FWD_WB;
      end
   end

endmodule : forward_unit

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
//------------------------------------------------------------------------------
// Module      : pipeline_ctrl
// Description : Hazard and sequencing controller for the 5-stage pipeline.
//               Forwarding selects, load-use stall, taken-branch flush and a
//               registered PC redirect one cycle after branch resolution.
//               Optional build macro PIPE_CTRL_PERF_EN adds saturating
//               stall_cnt / flush_cnt performance counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic [4:0]  ex_rs,
   input  logic [4:0]  ex_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_write_reg,
   input  logic        ex_branch,
   input  logic        ex_alu_zero,
   input  logic [31:0] ex_pc_branch,
   input  logic        mem_reg_write,
   input  logic        wb_reg_write,
   input  logic [4:0]  mem_write_reg,
   input  logic [4:0]  wb_write_reg,
   input  logic        mem_busy,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        idex_write,
   output logic        exmem_write,
   output logic        idex_bubble,
   output logic        memwb_bubble,
   output logic        ifid_flush,
   output logic        pc_src,
   output logic [31:0] pc_redirect
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   state_e      state_q, state_d;
   logic [31:0] tgt_q, tgt_d;
   logic        lu;
   logic        tk;
   logic        stall_applied;
   logic        flush_applied;

   forward_unit u_forward_unit (
      .ex_rs         (ex_rs),
      .ex_rt         (ex_rt),
      .mem_reg_write (mem_reg_write),
      .mem_write_reg (mem_write_reg),
      .wb_reg_write  (wb_reg_write),
      .wb_write_reg  (wb_write_reg),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b)
   );

   // Load in EX whose destination is read by the instruction in ID
   assign lu = ex_mem_read && (ex_write_reg != 5'd0) &&
               ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
   assign tk = ex_branch && ex_alu_zero;

   // Next state and stage controls; mem_busy freezes everything, then the
   // pending redirect, then a taken branch, then a load-use stall
   always_comb begin
      state_d       = state_q;
      tgt_d         = tgt_q;
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      idex_write    = 1'b1;
      exmem_write   = 1'b1;
      idex_bubble   = 1'b0;
      memwb_bubble  = 1'b0;
      ifid_flush    = 1'b0;
      pc_src        = 1'b0;
      stall_applied = 1'b0;
      flush_applied = 1'b0;
      if (mem_busy) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         memwb_bubble = 1'b1;
      end else if (state_q == REDIRECT) begin
         // ID/EX hold wrong-path work or bubbles here, so hazards are ignored
         pc_src      = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         state_d     = RUN;
      end else if (tk) begin
         ifid_flush    = 1'b1;
         idex_bubble   = 1'b1;
         tgt_d         = ex_pc_branch;
         state_d       = REDIRECT;
         flush_applied = 1'b1;
      end else if (lu) begin
         pc_write      = 1'b0;
         ifid_write    = 1'b0;
         idex_bubble   = 1'b1;
         stall_applied = 1'b1;
      end
   end

   // State and branch-target registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         tgt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

   assign pc_redirect = tgt_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters; busy cycles never raise either event
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_applied && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (flush_applied && (flush_cnt_q != 32'hFFFF_FFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic unused_events;
   assign unused_events = stall_applied ^ flush_applied;
`endif

endmodule : pipeline_ctrl

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_pipeline_ctrl
// Description : Scoreboard bench for pipeline_ctrl. Directed per-cycle input
//               vectors push hand-computed expected outputs into a queue; an
//               independent monitor pops and compares each cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_ctrl;

   logic        clk;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
   logic        id_uses_rt, ex_mem_read, ex_branch, ex_alu_zero;
   logic        mem_reg_write, wb_reg_write, mem_busy;
   logic [31:0] ex_pc_branch;
   logic [1:0]  fwd_a, fwd_b;
   logic        pc_write, ifid_write, idex_write, exmem_write;
   logic        idex_bubble, memwb_bubble, ifid_flush, pc_src;
   logic [31:0] pc_redirect;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   pipeline_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rt    (id_uses_rt),
      .ex_rs         (ex_rs),
      .ex_rt         (ex_rt),
      .ex_mem_read   (ex_mem_read),
      .ex_write_reg  (ex_write_reg),
      .ex_branch     (ex_branch),
      .ex_alu_zero   (ex_alu_zero),
      .ex_pc_branch  (ex_pc_branch),
      .mem_reg_write (mem_reg_write),
      .wb_reg_write  (wb_reg_write),
      .mem_write_reg (mem_write_reg),
      .wb_write_reg  (wb_write_reg),
      .mem_busy      (mem_busy),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b),
      .pc_write      (pc_write),
      .ifid_write    (ifid_write),
      .idex_write    (idex_write),
      .exmem_write   (exmem_write),
      .idex_bubble   (idex_bubble),
      .memwb_bubble  (memwb_bubble),
      .ifid_flush    (ifid_flush),
      .pc_src        (pc_src),
      .pc_redirect   (pc_redirect)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control vector: {pc_write, ifid_write, idex_write, exmem_write,
   //                  idex_bubble, memwb_bubble, ifid_flush, pc_src}
   localparam logic [7:0] C_IDLE  = 8'b1111_0000;
   localparam logic [7:0] C_LU    = 8'b0011_1000;
   localparam logic [7:0] C_TK    = 8'b1111_1010;
   localparam logic [7:0] C_REDIR = 8'b1111_1011;
   localparam logic [7:0] C_BUSY  = 8'b0000_0100;

   typedef struct {
      string       name;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [7:0]  ctrl;
      logic [31:0] redir;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   pushed = 0;
   int   popped = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         popped++;
         chk({e.name, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, e.fa});
         chk({e.name, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, e.fb});
         chk({e.name, ".ctrl"},
             {24'd0, pc_write, ifid_write, idex_write, exmem_write,
              idex_bubble, memwb_bubble, ifid_flush, pc_src},
             {24'd0, e.ctrl});
         chk({e.name, ".pc_redirect"}, pc_redirect, e.redir);
`ifdef PIPE_CTRL_PERF_EN
         chk({e.name, ".stall_cnt"}, stall_cnt, e.sc);
         chk({e.name, ".flush_cnt"}, flush_cnt, e.fc);
`endif
      end
   end

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
      ex_rs = 5'd0; ex_rt = 5'd0; ex_mem_read = 1'b0; ex_write_reg = 5'd0;
      ex_branch = 1'b0; ex_alu_zero = 1'b0; ex_pc_branch = 32'd0;
      mem_reg_write = 1'b0; mem_write_reg = 5'd0;
      wb_reg_write = 1'b0; wb_write_reg = 5'd0;
      mem_busy = 1'b0;
   endtask

   // Push the expectation for the cycle just driven, then advance one cycle
   task automatic step(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [7:0] ctrl, input logic [31:0] redir,
                       input logic [31:0] sc, input logic [31:0] fc);
      exp_t e;
      e.name = nm; e.fa = fa; e.fb = fb; e.ctrl = ctrl;
      e.redir = redir; e.sc = sc; e.fc = fc;
      exp_q.push_back(e);
      pushed++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      step("reset", 2'b00, 2'b00, C_IDLE, 32'h0, 0, 0);
      rst_n = 1'b1;

      // Forwarding
      idle_inputs();
      mem_reg_write = 1'b1; mem_write_reg = 5'd5;
      wb_reg_write = 1'b1; wb_write_reg = 5'd5; ex_rs = 5'd5; ex_rt = 5'd7;
      step("fwd_mem_prio", 2'b10, 2'b00, C_IDLE, 32'h0, 0, 0);
      mem_reg_write = 1'b0;
      step("fwd_wb", 2'b01, 2'b00, C_IDLE, 32'h0, 0, 0);
      idle_inputs();
      mem_reg_write = 1'b1; wb_reg_write = 1'b1;
      step("fwd_r0", 2'b00, 2'b00, C_IDLE, 32'h0, 0, 0);
      idle_inputs();
      mem_reg_write = 1'b1; mem_write_reg = 5'd4; ex_rs = 5'd4;
      wb_reg_write = 1'b1; wb_write_reg = 5'd3; ex_rt = 5'd3;
      step("fwd_split", 2'b10, 2'b01, C_IDLE, 32'h0, 0, 0);

      // Load-use: one-cycle stall, then MEM forwarding
      idle_inputs();
      ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_rt = 5'd8; id_rs = 5'd1; id_uses_rt = 1'b1;
      step("lu_rt", 2'b00, 2'b00, C_LU, 32'h0, 0, 0);
      idle_inputs();
      mem_reg_write = 1'b1; mem_write_reg = 5'd8; ex_rt = 5'd8;
      step("lu_after", 2'b00, 2'b10, C_IDLE, 32'h0, 1, 0);
      idle_inputs();
      ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_rt = 5'd8; id_rs = 5'd2;
      step("lu_no_rt", 2'b00, 2'b00, C_IDLE, 32'h0, 1, 0);
      idle_inputs();
      ex_mem_read = 1'b1;
      step("lu_r0", 2'b00, 2'b00, C_IDLE, 32'h0, 1, 0);

      // Taken branch and registered redirect
      idle_inputs();
      ex_branch = 1'b1; ex_alu_zero = 1'b1; ex_pc_branch = 32'h0000_0040;
      step("tk", 2'b00, 2'b00, C_TK, 32'h0, 1, 0);
      idle_inputs();
      step("redir", 2'b00, 2'b00, C_REDIR, 32'h40, 1, 1);
      step("post_redir", 2'b00, 2'b00, C_IDLE, 32'h40, 1, 1);
      ex_branch = 1'b1;
      step("not_taken", 2'b00, 2'b00, C_IDLE, 32'h40, 1, 1);

      // Branch and load-use together: branch only
      idle_inputs();
      ex_branch = 1'b1; ex_alu_zero = 1'b1; ex_pc_branch = 32'h0000_0080;
      ex_mem_read = 1'b1; ex_write_reg = 5'd9; id_rs = 5'd9;
      step("tk_lu", 2'b00, 2'b00, C_TK, 32'h40, 1, 1);
      idle_inputs();
      ex_mem_read = 1'b1; ex_write_reg = 5'd9; id_rs = 5'd9;
      step("redir_ign_lu", 2'b00, 2'b00, C_REDIR, 32'h80, 1, 2);
      idle_inputs();
      step("idle2", 2'b00, 2'b00, C_IDLE, 32'h80, 1, 2);

      // mem_busy holding a pending redirect
      ex_branch = 1'b1; ex_alu_zero = 1'b1; ex_pc_branch = 32'h0000_0040;
      step("tk2", 2'b00, 2'b00, C_TK, 32'h80, 1, 2);
      idle_inputs();
      mem_busy = 1'b1;
      step("busy1", 2'b00, 2'b00, C_BUSY, 32'h40, 1, 3);
      ex_mem_read = 1'b1; ex_write_reg = 5'd6; id_rs = 5'd6;
      step("busy2", 2'b00, 2'b00, C_BUSY, 32'h40, 1, 3);
      step("busy3", 2'b00, 2'b00, C_BUSY, 32'h40, 1, 3);
      idle_inputs();
      step("redir_after_busy", 2'b00, 2'b00, C_REDIR, 32'h40, 1, 3);
      step("idle3", 2'b00, 2'b00, C_IDLE, 32'h40, 1, 3);

      // Reset asserted while REDIRECT is pending
      ex_branch = 1'b1; ex_alu_zero = 1'b1; ex_pc_branch = 32'h0000_0100;
      step("tk3", 2'b00, 2'b00, C_TK, 32'h40, 1, 3);
      idle_inputs();
      rst_n = 1'b0;
      step("rst_in_redir", 2'b00, 2'b00, C_IDLE, 32'h0, 0, 0);
      rst_n = 1'b1;
      step("after_rst", 2'b00, 2'b00, C_IDLE, 32'h0, 0, 0);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      checks++;
      if (popped != pushed) begin
         errors++;
         $display("FAIL drain: got %0d popped expected %0d", popped, pushed);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pipeline_ctrl

`default_nettype wire
